// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: shares one 8-bit memory bus between the CPU and a sprite-DMA engine.
// A DMA request halts the CPU on its next read cycle. Writes are never halted. The
// arbiter spends one halt cycle, plus one align cycle when needed, so that the first
// DMA cycle always falls on even parity. It then hands the bus to the DMA engine
// until the request drops.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_cpu_addr/wn/wdata    CPU bus cycle (wn active low)
//   o_cpu_rdy, o_cpu_rdata CPU ready (0 = halted), read data
//   i_spr_req, o_spr_gnt   DMA request, per-cycle transfer grant
//   i_spr_addr/wn/wdata    DMA bus cycle
//   o_spr_rdata            read data to DMA
//   o_bus_addr/wn/wdata    shared bus outputs
//   i_bus_rdata            shared bus read data (same cycle)
//   o_stall_cnt            CPU cycles halted in the last/current DMA
module cpu_bus_arb #(
  parameter int unsigned STALL_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [15:0]        i_cpu_addr,
  input  logic               i_cpu_wn,
  input  logic [7:0]         i_cpu_wdata,
  output logic               o_cpu_rdy,
  output logic [7:0]         o_cpu_rdata,
  input  logic               i_spr_req,
  output logic               o_spr_gnt,
  input  logic [15:0]        i_spr_addr,
  input  logic               i_spr_wn,
  input  logic [7:0]         i_spr_wdata,
  output logic [7:0]         o_spr_rdata,
  output logic [15:0]        o_bus_addr,
  output logic               o_bus_wn,
  output logic [7:0]         o_bus_wdata,
  input  logic [7:0]         i_bus_rdata,
  output logic [STALL_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ArbCpu   = 2'd0,
    ArbHalt  = 2'd1,
    ArbAlign = 2'd2,
    ArbDma   = 2'd3
  } arb_state_e;

  arb_state_e         state_q, state_d;
  logic               r_odd;
  logic [STALL_W-1:0] stall_q, stall_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ArbCpu;
      r_odd   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      r_odd   <= ~r_odd;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = ArbCpu;
    case (state_q)
      // Only a read cycle can be halted; a write in flight must complete.
      ArbCpu:   state_d = (i_spr_req && i_cpu_wn) ? ArbHalt : ArbCpu;
      // Odd parity now means the next cycle is even, so DMA may start straight away.
      ArbHalt:  state_d = !i_spr_req ? ArbCpu : (r_odd ? ArbDma : ArbAlign);
      ArbAlign: state_d = i_spr_req ? ArbDma : ArbCpu;
      ArbDma:   state_d = i_spr_req ? ArbDma : ArbCpu;
      default:  state_d = ArbCpu;
    endcase
  end

  // Counts halted cycles while the request is still held. The closing cycle after
  // the request drops is not counted, so a halt + align + N grants reads N + 2.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ArbCpu) begin
      if (state_d == ArbHalt) stall_d = '0;
    end else if (i_spr_req && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    o_cpu_rdy   = (state_q == ArbCpu);
    o_spr_gnt   = (state_q == ArbDma) && i_spr_req;
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    case (state_q)
      ArbDma: begin
        o_bus_addr  = i_spr_addr;
        o_bus_wn    = i_spr_wn;
        o_bus_wdata = i_spr_wdata;
      end
      // A halted CPU keeps presenting its address. Force a dummy read so that a
      // write is not repeated.
      ArbHalt, ArbAlign: begin
        o_bus_wn    = 1'b1;
        o_bus_wdata = 8'h00;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdata = i_bus_rdata;
  assign o_spr_rdata = i_bus_rdata;
  assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_cpu_bus_arb.sv
module tb_cpu_bus_arb;
  localparam int STALL_W   = 10;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic               i_clk, i_rstn;
  logic [15:0]        i_cpu_addr, i_spr_addr, o_bus_addr;
  logic               i_cpu_wn, i_spr_wn, o_bus_wn, i_spr_req, o_spr_gnt, o_cpu_rdy;
  logic [7:0]         i_cpu_wdata, i_spr_wdata, o_bus_wdata, i_bus_rdata;
  logic [7:0]         o_cpu_rdata, o_spr_rdata;
  logic [STALL_W-1:0] o_stall_cnt;

  cpu_bus_arb #(.STALL_W(STALL_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wn(i_cpu_wn), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdy(o_cpu_rdy), .o_cpu_rdata(o_cpu_rdata),
    .i_spr_req(i_spr_req), .o_spr_gnt(o_spr_gnt),
    .i_spr_addr(i_spr_addr), .i_spr_wn(i_spr_wn), .i_spr_wdata(i_spr_wdata),
    .o_spr_rdata(o_spr_rdata),
    .o_bus_addr(o_bus_addr), .o_bus_wn(o_bus_wn), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: whether the CPU is halted, how many setup (non-transfer)
  // cycles remain before grants begin, stall count, and edges since reset.
  bit m_halted;
  int m_setup;
  int m_stall;
  int m_cyc;

  logic        e_rdy, e_gnt, e_wn;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;

  task automatic model_reset();
    m_halted = 0; m_setup = 0; m_stall = 0; m_cyc = 0;
  endtask

  task automatic model_eval();
    e_rdy = !m_halted;
    e_gnt = m_halted && (m_setup == 0) && i_spr_req;
    if (!m_halted) begin
      e_addr = i_cpu_addr; e_wn = i_cpu_wn; e_wdata = i_cpu_wdata;
    end else if (m_setup > 0) begin
      e_addr = i_cpu_addr; e_wn = 1'b1; e_wdata = 8'h00;
    end else begin
      e_addr = i_spr_addr; e_wn = i_spr_wn; e_wdata = i_spr_wdata;
    end
  endtask

  // Advance the model using the inputs present before the edge, then cross the edge.
  task automatic tick();
    if (i_rstn) begin
      if (!m_halted) begin
        if (i_spr_req && i_cpu_wn) begin
          m_halted = 1;
          m_stall  = 0;
          // The first grant must land on an even cycle count since reset.
          m_setup  = ((m_cyc + 2) % 2 == 0) ? 1 : 2;
        end
      end else if (!i_spr_req) begin
        m_halted = 0;
        m_setup  = 0;
      end else begin
        if (m_stall < STALL_MAX) m_stall++;
        if (m_setup > 0) m_setup--;
      end
      m_cyc++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_spr_req = 1'b1; i_cpu_wn = 1'b1; i_cpu_addr = 16'h4321;
    model_reset();
    #12;
    vectors++;
    if (o_cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", o_cpu_rdy); end
    vectors++;
    if (o_spr_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", o_spr_gnt); end
    vectors++;
    if (o_stall_cnt !== '0) begin errors++; $display("FAIL reset_stall: got %0d want 0", o_stall_cnt); end
    vectors++;
    if (o_bus_addr !== 16'h4321) begin
      errors++; $display("FAIL reset_bus_addr: got %h want 4321", o_bus_addr);
    end
    i_spr_req = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    model_reset();
    tick();
  endtask

  // The halt cycle sees odd parity, so DMA follows the halt directly.
  task automatic test_halt_direct();
    i_spr_req = 1'b0; i_cpu_wn = 1'b1;
    if (m_cyc % 2 == 1) tick();
    i_cpu_addr = 16'h1234; i_spr_addr = 16'hA5A0; i_spr_wn = 1'b0; i_spr_wdata = 8'h3C;
    i_spr_req = 1'b1;
    #1;
    vectors++;
    if (o_cpu_rdy !== 1'b1) begin errors++; $display("FAIL direct_pre_rdy: got %b want 1", o_cpu_rdy); end
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b0 || o_spr_gnt !== 1'b0) begin
      errors++; $display("FAIL direct_halt: rdy/gnt got %b%b want 00", o_cpu_rdy, o_spr_gnt);
    end
    tick();
    vectors++;
    if (o_spr_gnt !== 1'b1 || o_bus_addr !== 16'hA5A0 || o_bus_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL direct_dma: gnt/addr/wdata got %b %h %h want 1 a5a0 3c",
               o_spr_gnt, o_bus_addr, o_bus_wdata);
    end
    i_spr_req = 1'b0;
    #1;
    vectors++;
    if (o_spr_gnt !== 1'b0) begin errors++; $display("FAIL direct_drop_gnt: got %b want 0", o_spr_gnt); end
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b1 || o_stall_cnt !== 10'd1) begin
      errors++; $display("FAIL direct_end: rdy/stall got %b %0d want 1 1", o_cpu_rdy, o_stall_cnt);
    end
  endtask

  task automatic test_align_long_dma();
    int ngnt = 0;
    int nbad = 0;
    i_spr_req = 1'b0; i_cpu_wn = 1'b1;
    if (m_cyc % 2 == 0) tick();
    i_spr_req = 1'b1;
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b0) begin errors++; $display("FAIL align_halt_rdy: got %b want 0", o_cpu_rdy); end
    tick();
    vectors++;
    if (o_spr_gnt !== 1'b0 || o_bus_wn !== 1'b1) begin
      errors++; $display("FAIL align_cycle: gnt/wn got %b %b want 0 1", o_spr_gnt, o_bus_wn);
    end
    tick();
    for (int k = 0; k < 512; k++) begin
      i_spr_addr = 16'($urandom); i_spr_wn = 1'($urandom); i_spr_wdata = 8'($urandom);
      #1;
      if (o_spr_gnt === 1'b1) ngnt++;
      if (o_bus_addr !== i_spr_addr || o_bus_wn !== i_spr_wn) nbad++;
      tick();
    end
    vectors++;
    if (ngnt != 512 || nbad != 0) begin
      errors++; $display("FAIL align_grants: got %0d grants %0d bad bus want 512 0", ngnt, nbad);
    end
    i_spr_req = 1'b0;
    #1;
    vectors++;
    if (o_spr_gnt !== 1'b0 || o_cpu_rdy !== 1'b0) begin
      errors++; $display("FAIL align_close: gnt/rdy got %b %b want 0 0", o_spr_gnt, o_cpu_rdy);
    end
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b1 || o_stall_cnt !== 10'd514) begin
      errors++; $display("FAIL align_stall: rdy/stall got %b %0d want 1 514", o_cpu_rdy, o_stall_cnt);
    end
    tick(); tick();
    vectors++;
    if (o_stall_cnt !== 10'd514) begin
      errors++; $display("FAIL stall_hold: got %0d want 514", o_stall_cnt);
    end
  endtask

  task automatic test_writes_no_halt();
    i_spr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_cpu_wn = 1'b0; i_cpu_addr = 16'h2000 + 16'(k); i_cpu_wdata = 8'($urandom);
      #1;
      vectors++;
      if (o_cpu_rdy !== 1'b1 || o_bus_wn !== 1'b0 || o_bus_addr !== i_cpu_addr ||
          o_bus_wdata !== i_cpu_wdata || o_spr_gnt !== 1'b0) begin
        errors++;
        $display("FAIL write_%0d: rdy/wn/addr/wdata got %b %b %h %h want 1 0 %h %h",
                 k, o_cpu_rdy, o_bus_wn, o_bus_addr, o_bus_wdata, i_cpu_addr, i_cpu_wdata);
      end
      tick();
    end
    i_cpu_wn = 1'b1;
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b0) begin errors++; $display("FAIL write_then_read: got %b want 0", o_cpu_rdy); end
    i_spr_req = 1'b0;
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b1) begin errors++; $display("FAIL write_cleanup: got %b want 1", o_cpu_rdy); end
  endtask

  task automatic test_drop_in_align();
    int bad = 0;
    i_spr_req = 1'b0; i_cpu_wn = 1'b1;
    if (m_cyc % 2 == 0) tick();
    i_cpu_addr = 16'h0100; i_spr_addr = 16'hBEEF; i_spr_req = 1'b1;
    tick();
    #1;
    if (o_spr_gnt !== 1'b0 || o_bus_addr === 16'hBEEF) bad++;
    tick();
    #1;
    if (o_spr_gnt !== 1'b0 || o_bus_addr === 16'hBEEF || o_cpu_rdy !== 1'b0) bad++;
    i_spr_req = 1'b0;
    #1;
    if (o_spr_gnt !== 1'b0) bad++;
    tick();
    vectors++;
    if (bad != 0 || o_cpu_rdy !== 1'b1 || o_bus_addr !== 16'h0100) begin
      errors++;
      $display("FAIL align_drop: bad %0d rdy %b addr %h want 0 1 0100", bad, o_cpu_rdy, o_bus_addr);
    end
  endtask

  task automatic test_halt_write_dummy();
    i_cpu_wn = 1'b1; i_spr_req = 1'b1;
    tick();
    i_cpu_wn = 1'b0; i_cpu_addr = 16'h3000; i_cpu_wdata = 8'h5A;
    #1;
    vectors++;
    if (o_bus_wn !== 1'b1 || o_bus_addr !== 16'h3000 || o_bus_wdata !== 8'h00) begin
      errors++;
      $display("FAIL halt_dummy: wn/addr/wdata got %b %h %h want 1 3000 00",
               o_bus_wn, o_bus_addr, o_bus_wdata);
    end
    i_spr_req = 1'b0;
    tick();
    vectors++;
    if (o_cpu_rdy !== 1'b1 || o_spr_gnt !== 1'b0) begin
      errors++; $display("FAIL halt_drop: rdy/gnt got %b %b want 1 0", o_cpu_rdy, o_spr_gnt);
    end
    i_cpu_wn = 1'b1;
  endtask

  task automatic test_reset_mid_dma();
    int waited = 0;
    int bad = 0;
    i_cpu_wn = 1'b1; i_spr_req = 1'b1;
    while (o_spr_gnt !== 1'b1 && waited < 4) begin tick(); waited++; end
    vectors++;
    if (o_spr_gnt !== 1'b1) begin errors++; $display("FAIL rst_dma_entry: got %b want 1", o_spr_gnt); end
    tick(); tick();
    #3;
    i_rstn = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (o_cpu_rdy !== 1'b1 || o_spr_gnt !== 1'b0 || o_stall_cnt !== '0) begin
      errors++;
      $display("FAIL rst_async: rdy/gnt/stall got %b %b %0d want 1 0 0", o_cpu_rdy, o_spr_gnt, o_stall_cnt);
    end
    tick(); tick();
    i_spr_req = 1'b0;
    #3;
    i_rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_spr_gnt !== 1'b0 || o_cpu_rdy !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_gnt: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) i_spr_req = ~i_spr_req;
      i_cpu_wn    = ($urandom_range(0, 3) != 0);
      i_cpu_addr  = 16'($urandom); i_cpu_wdata = 8'($urandom);
      i_spr_addr  = 16'($urandom); i_spr_wdata = 8'($urandom); i_spr_wn = 1'($urandom);
      i_bus_rdata = 8'($urandom);
      #1;
      model_eval();
      vectors++;
      if (o_cpu_rdy !== e_rdy || o_spr_gnt !== e_gnt) begin
        errors++; $display("FAIL rand_ctl @%0d: rdy/gnt got %b%b want %b%b", k, o_cpu_rdy, o_spr_gnt, e_rdy, e_gnt);
      end
      vectors++;
      if (o_bus_addr !== e_addr || o_bus_wn !== e_wn || o_bus_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rand_bus @%0d: got %h %b %h want %h %b %h",
                 k, o_bus_addr, o_bus_wn, o_bus_wdata, e_addr, e_wn, e_wdata);
      end
      vectors++;
      if (o_cpu_rdata !== i_bus_rdata || o_spr_rdata !== i_bus_rdata) begin
        errors++; $display("FAIL rand_rdata @%0d: got %h %h want %h", k, o_cpu_rdata, o_spr_rdata, i_bus_rdata);
      end
      vectors++;
      if (o_stall_cnt !== STALL_W'(m_stall)) begin
        errors++; $display("FAIL rand_stall @%0d: got %0d want %0d", k, o_stall_cnt, m_stall);
      end
      tick();
    end
  endtask

  initial begin
    i_cpu_addr = '0; i_cpu_wn = 1'b1; i_cpu_wdata = '0; i_spr_req = 1'b0;
    i_spr_addr = '0; i_spr_wn = 1'b1; i_spr_wdata = '0; i_bus_rdata = 8'h96;
    test_reset();
    test_halt_direct();
    test_align_long_dma();
    test_writes_no_halt();
    test_drop_in_align();
    test_halt_write_dummy();
    test_reset_mid_dma();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
